// File: rtl/fifo_pkg.sv
// Shared FIFO geometry for the 16x8 FIFO controller and the parent that owns the RAM.
package fifo_pkg;
   localparam int unsigned FIFO_DATA_W = 8;
   localparam int unsigned FIFO_ADDR_W = 4;
   localparam int unsigned FIFO_DEPTH  = 2 ** FIFO_ADDR_W;
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: PTR_W-bit counter whose MSB acts as the wrap bit.
module fifo_ptr #(
   parameter int unsigned PTR_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/sync_fifo_ctrl_16x8.sv
// FIFO controller for an external dual-port synchronous RAM (1-cycle registered read).
module sync_fifo_ctrl_16x8
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned ADDR_W = FIFO_ADDR_W,
   parameter int unsigned DEPTH  = FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   output logic              ram_wr_enb,
   output logic              ram_rd_enb,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [ADDR_W-1:0] ram_rd_addr,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic              wr_fire;
   logic              pop_fire;
   logic [DATA_W-1:0] pop_hold;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
   assign count    = wr_ptr - rd_ptr;

   // A pop frees a slot in the same cycle, so a push is still accepted when full.
   assign pop_fire = pop && !empty;
   assign wr_fire  = push && (!full || pop_fire);

   assign ram_wr_enb  = wr_fire;
   assign ram_wr_addr = wr_ptr[ADDR_W-1:0];
   assign ram_data_in = push_data;
   assign ram_rd_enb  = pop_fire;
   assign ram_rd_addr = rd_ptr[ADDR_W-1:0];

   fifo_ptr #(.PTR_W(ADDR_W + 1)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wr_fire),
      .ptr   (wr_ptr)
   );

   fifo_ptr #(.PTR_W(ADDR_W + 1)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop_fire),
      .ptr   (rd_ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_valid <= 1'b0;
         pop_hold  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pop_valid <= pop_fire;
         if (pop_valid) begin
            pop_hold <= ram_data_out;
         end
         if (push && !wr_fire) begin
            overflow <= 1'b1;
         end
         if (pop && !pop_fire) begin
            underflow <= 1'b1;
         end
      end
   end

   // RAM read data is only live in the pop_valid cycle; otherwise replay the last one.
   assign pop_data = pop_valid ? ram_data_out : pop_hold;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (count <= DEPTH_CNT);
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl_16x8.sv
// Directed scoreboard bench for sync_fifo_ctrl_16x8 driving a 16x8 read-before-write RAM model.
module tb_sync_fifo_ctrl_16x8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       push;
   logic [7:0] push_data;
   logic       pop;
   logic [7:0] pop_data;
   logic       pop_valid;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;
   logic       ram_wr_enb;
   logic       ram_rd_enb;
   logic [3:0] ram_wr_addr;
   logic [3:0] ram_rd_addr;
   logic [7:0] ram_data_in;
   logic [7:0] ram_data_out;

   logic       ram_rst_n = 1'b1;
   logic [7:0] mem [16];

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   logic [7:0] fifo_m [$];
   logic [7:0] sb_q [$];
   logic [4:0] wr_m;
   logic [4:0] rd_m;
   logic       m_ov;
   logic       m_un;
   logic [7:0] last_pd;

   always #5 clk = ~clk;

   sync_fifo_ctrl_16x8 #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (push),
      .push_data    (push_data),
      .pop          (pop),
      .pop_data     (pop_data),
      .pop_valid    (pop_valid),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .ram_wr_enb   (ram_wr_enb),
      .ram_rd_enb   (ram_rd_enb),
      .ram_wr_addr  (ram_wr_addr),
      .ram_rd_addr  (ram_rd_addr),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out)
   );

   // Dual-port synchronous RAM, registered read, old data on same-address read/write.
   always @(posedge clk or negedge ram_rst_n) begin
      if (!ram_rst_n) begin
         ram_data_out <= '0;
      end else begin
         if (ram_rd_enb) ram_data_out <= mem[ram_rd_addr];
         if (ram_wr_enb) mem[ram_wr_addr] <= ram_data_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      fifo_m.delete();
      sb_q.delete();
      wr_m    = '0;
      rd_m    = '0;
      m_ov    = 1'b0;
      m_un    = 1'b0;
      last_pd = '0;
   endtask

   task automatic check_state();
      chk("count", 32'(count), 32'(fifo_m.size()));
      chk("full", 32'(full), 32'(fifo_m.size() == 16));
      chk("empty", 32'(empty), 32'(fifo_m.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
   endtask

   task automatic step(input logic p, input logic [7:0] d, input logic q);
      int unsigned n;
      logic        exp_wr;
      logic        exp_rd;
      logic [7:0]  exp_d;
      n      = fifo_m.size();
      exp_rd = q && (n != 0);
      exp_wr = p && ((n < 16) || exp_rd);
      push      = p;
      push_data = d;
      pop       = q;
      #1;
      chk("ram_wr_enb", 32'(ram_wr_enb), 32'(exp_wr));
      chk("ram_rd_enb", 32'(ram_rd_enb), 32'(exp_rd));
      if (exp_wr) begin
         chk("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_m[3:0]));
         chk("ram_data_in", 32'(ram_data_in), 32'(d));
      end
      if (exp_rd) chk("ram_rd_addr", 32'(ram_rd_addr), 32'(rd_m[3:0]));
      if (exp_rd) begin
         sb_q.push_back(fifo_m.pop_front());
         rd_m = rd_m + 5'd1;
      end
      if (exp_wr) begin
         fifo_m.push_back(d);
         wr_m = wr_m + 5'd1;
      end
      if (p && !exp_wr) m_ov = 1'b1;
      if (q && !exp_rd) m_un = 1'b1;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      chk("pop_valid", 32'(pop_valid), 32'(exp_rd));
      if (exp_rd) begin
         if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'(1), 32'(0));
         end else begin
            exp_d   = sb_q.pop_front();
            last_pd = exp_d;
            chk("pop_data", 32'(pop_data), 32'(exp_d));
         end
      end else begin
         chk("pop_data_hold", 32'(pop_data), 32'(last_pd));
      end
      check_state();
   endtask

   initial begin
      rst_n     = 1'b0;
      push      = 1'b0;
      push_data = '0;
      pop       = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_state();
      chk("rst_pop_valid", 32'(pop_valid), 32'(0));
      chk("rst_pop_data", 32'(pop_data), 32'(0));
      chk("rst_ram_wr_enb", 32'(ram_wr_enb), 32'(0));
      chk("rst_ram_rd_enb", 32'(ram_rd_enb), 32'(0));
      rst_n = 1'b1;

      // fill with 0x11..0x20
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
      chk("fill_full", 32'(full), 32'(1));
      chk("fill_count", 32'(count), 32'(16));

      // overflow: 0xAA dropped
      step(1'b1, 8'hAA, 1'b0);
      chk("ovf_sticky", 32'(overflow), 32'(1));

      // full push+pop: oldest out, 0x55 becomes newest
      step(1'b1, 8'h55, 1'b1);
      chk("full_pp_count", 32'(count), 32'(16));

      // drain: 0x12..0x20 then 0x55, never 0xAA
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
      chk("drain_empty", 32'(empty), 32'(1));
      step(1'b0, 8'h00, 1'b0);
      chk("hold_last", 32'(pop_data), 32'(8'h55));

      // underflow on empty pop
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      chk("unf_sticky", 32'(underflow), 32'(1));

      // empty push+pop: push only
      step(1'b1, 8'h77, 1'b1);
      chk("empty_pp_count", 32'(count), 32'(1));

      // interleaved stream across the pointer wrap
      for (int i = 0; i < 28; i++) begin
         step(i < 24, 8'(8'hC0 + i), i >= 3);
      end
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
      step(1'b1, 8'h40, 1'b1);

      // asynchronous reset mid-stream with a pop requested
      pop = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("arst_empty", 32'(empty), 32'(1));
      chk("arst_count", 32'(count), 32'(0));
      chk("arst_pop_valid", 32'(pop_valid), 32'(0));
      chk("arst_ovf", 32'(overflow), 32'(0));
      chk("arst_unf", 32'(underflow), 32'(0));
      @(posedge clk);
      #1;
      chk("arst_pv_next", 32'(pop_valid), 32'(0));
      check_state();
      pop   = 1'b0;
      rst_n = 1'b1;

      // recovery after reset
      step(1'b1, 8'h9A, 1'b0);
      step(1'b1, 8'h9B, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
